cmd_cfg: RTL and testbench

Command-configuration stage of the QuadCopter that consumes decoded 24-bit wireless commands (opcode + 16-bit data) from the UART wrapper. It holds the flight setpoints (desired pitch/roll/yaw, thrust) that feed the flight controller. It sequences motor spin-up and inertial calibration and issues the one-byte response frame back through the UART wrapper. A watchdog forces an emergency landing when commands stop arriving.

---
 rtl/quad_pkg.sv | 34 +++
 rtl/cmd_cfg_wdog.sv | 43 ++++
 rtl/cmd_cfg.sv | 149 ++++++++++++++
 tb/tb_cmd_cfg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: opcodes, response bytes, FSM states and counter widths
// shared by the QuadCopter command-configuration path.
package quad_pkg;

   typedef enum logic [7:0] {
      REQ_BATT  = 8'h01,
      SET_PTCH  = 8'h02,
      SET_ROLL  = 8'h03,
      SET_YAW   = 8'h04,
      SET_THRST = 8'h05,
      CALIBRATE = 8'h06,
      EMER_LAND = 8'h07,
      MTRS_OFF  = 8'h08
   } opcode_e;

   localparam logic [7:0] ACK_BYTE  = 8'hA5;
   localparam logic [7:0] NACK_BYTE = 8'hEE;

   typedef enum logic [1:0] {
      IDLE,
      SPINUP,
      CAL,
      RESP_WAIT
   } state_e;

   function automatic int spin_w(input int fast);
      return (fast != 0) ? 9 : 19;
   endfunction

   function automatic int wdog_w(input int fast);
      return (fast != 0) ? 12 : 26;
   endfunction

endpackage

// File: rtl/cmd_cfg_wdog.sv
// cmd_cfg_wdog: saturating command watchdog; expire pulses once
// per run of 2^W - 1 clocks without a kick.
module cmd_cfg_wdog
   import quad_pkg::*;
#(
   parameter int W = wdog_w(0)
) (
   input  logic clk,
   input  logic rst,
   input  logic kick,
   output logic expire
);

   localparam logic [W-1:0] MAX = {W{1'b1}};
   localparam logic [W-1:0] TC  = {{(W-1){1'b1}}, 1'b0};

   logic [W-1:0] cnt_q, cnt_d;
   logic         exp_q, exp_d;

   always_comb begin
      cnt_d = cnt_q;
      if (kick)
         cnt_d = '0;
      else if (cnt_q != MAX)
         cnt_d = cnt_q + 1'b1;
   end

   // Fires only on the step into saturation, so never twice per expiry.
   assign exp_d = !kick && (cnt_q == TC);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         exp_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         exp_q <= exp_d;
      end
   end

   assign expire = exp_q;

endmodule

// File: rtl/cmd_cfg.sv
// cmd_cfg: decodes wireless commands into flight setpoints, sequences
// spin-up and inertial calibration, and returns a response byte.
module cmd_cfg
   import quad_pkg::*;
#(
   parameter int         FAST_SIM = 0,
   parameter logic [7:0] ACK      = ACK_BYTE,
   parameter logic [7:0] NACK     = NACK_BYTE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_rdy,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   output logic        clr_cmd_rdy,
   output logic [7:0]  resp,
   output logic        send_resp,
   input  logic        resp_sent,
   input  logic [7:0]  batt,
   input  logic        cal_done,
   output logic [15:0] d_ptch,
   output logic [15:0] d_roll,
   output logic [15:0] d_yaw,
   output logic [8:0]  thrst,
   output logic        strt_cal,
   output logic        inertial_cal,
   output logic        motors_off
);

   localparam int SPW = spin_w(FAST_SIM);
   localparam int WDW = wdog_w(FAST_SIM);

   state_e         state_q;
   logic [SPW-1:0] spin_q;
   logic [15:0]    ptch_q, roll_q, yaw_q;
   logic [8:0]     thrst_q;
   logic [7:0]     resp_q;
   logic           send_resp_q;
   logic           strt_cal_q;
   logic           inert_cal_q;
   logic           mtrs_off_q;
   logic           accept;
   logic           wd_exp;

   assign accept = (state_q == IDLE) && cmd_rdy;

   cmd_cfg_wdog #(
      .W(WDW)
   ) u_wdog (
      .clk   (clk),
      .rst   (rst),
      .kick  (accept),
      .expire(wd_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         spin_q      <= '0;
         ptch_q      <= '0;
         roll_q      <= '0;
         yaw_q       <= '0;
         thrst_q     <= '0;
         resp_q      <= '0;
         send_resp_q <= 1'b0;
         strt_cal_q  <= 1'b0;
         inert_cal_q <= 1'b0;
         mtrs_off_q  <= 1'b1;
      end else begin
         send_resp_q <= 1'b0;
         strt_cal_q  <= 1'b0;
         // Command loads below override this zeroing in the same cycle.
         if (wd_exp) begin
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            thrst_q <= '0;
         end
         unique case (state_q)
            IDLE: begin
               if (cmd_rdy) begin
                  resp_q      <= ACK;
                  send_resp_q <= 1'b1;
                  state_q     <= RESP_WAIT;
                  case (cmd)
                     REQ_BATT:  resp_q  <= batt;
                     SET_PTCH:  ptch_q  <= data;
                     SET_ROLL:  roll_q  <= data;
                     SET_YAW:   yaw_q   <= data;
                     SET_THRST: thrst_q <= data[8:0];
                     EMER_LAND: begin
                        ptch_q  <= '0;
                        roll_q  <= '0;
                        yaw_q   <= '0;
                        thrst_q <= '0;
                     end
                     MTRS_OFF:  mtrs_off_q <= 1'b1;
                     CALIBRATE: begin
                        resp_q      <= resp_q;
                        send_resp_q <= 1'b0;
                        mtrs_off_q  <= 1'b0;
                        ptch_q      <= '0;
                        roll_q      <= '0;
                        yaw_q       <= '0;
                        thrst_q     <= '0;
                        inert_cal_q <= 1'b1;
                        spin_q      <= '0;
                        state_q     <= SPINUP;
                     end
                     default:   resp_q <= NACK;
                  endcase
               end
            end
            SPINUP: begin
               spin_q <= spin_q + 1'b1;
               if (&spin_q) begin
                  strt_cal_q <= 1'b1;
                  state_q    <= CAL;
               end
            end
            CAL: begin
               if (cal_done) begin
                  inert_cal_q <= 1'b0;
                  resp_q      <= ACK;
                  send_resp_q <= 1'b1;
                  state_q     <= RESP_WAIT;
               end
            end
            RESP_WAIT: begin
               if (resp_sent)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clr_cmd_rdy  = accept;
   assign resp         = resp_q;
   assign send_resp    = send_resp_q;
   assign d_ptch       = ptch_q;
   assign d_roll       = roll_q;
   assign d_yaw        = yaw_q;
   assign thrst        = thrst_q;
   assign strt_cal     = strt_cal_q;
   assign inertial_cal = inert_cal_q;
   assign motors_off   = mtrs_off_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// tb_cmd_cfg: directed self-checking bench for cmd_cfg with FAST_SIM=1.
module tb_cmd_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_rdy = 1'b0;
   logic [7:0]  cmd = '0;
   logic [15:0] data = '0;
   logic        resp_sent = 1'b0;
   logic [7:0]  batt = '0;
   logic        cal_done = 1'b0;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic [15:0] d_ptch, d_roll, d_yaw;
   logic [8:0]  thrst;
   logic        strt_cal, inertial_cal, motors_off;

   int n_tests = 0;
   int n_fail  = 0;

   logic       c, s1, s2;
   logic [7:0] r;

   cmd_cfg #(.FAST_SIM(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_rdy     (cmd_rdy),
      .cmd         (cmd),
      .data        (data),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp        (resp),
      .send_resp   (send_resp),
      .resp_sent   (resp_sent),
      .batt        (batt),
      .cal_done    (cal_done),
      .d_ptch      (d_ptch),
      .d_roll      (d_roll),
      .d_yaw       (d_yaw),
      .thrst       (thrst),
      .strt_cal    (strt_cal),
      .inertial_cal(inertial_cal),
      .motors_off  (motors_off)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command in an IDLE cycle; the wrapper drops cmd_rdy after the edge.
   task automatic do_cmd(input logic [7:0] op, input logic [15:0] d,
                         output logic clr, output logic sr1,
                         output logic [7:0] rb, output logic sr2);
      cmd_rdy = 1'b1;
      cmd     = op;
      data    = d;
      #1 clr  = clr_cmd_rdy;
      @(posedge clk);
      #1;
      cmd_rdy = 1'b0;
      sr1     = send_resp;
      rb      = resp;
      tick();
      sr2     = send_resp;
   endtask

   task automatic finish_resp();
      resp_sent = 1'b1;
      tick();
      resp_sent = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      n_tests++; if ({d_ptch, d_roll, d_yaw} !== 48'h0) begin n_fail++; $display("FAIL reset_setpoints got %h want 0", {d_ptch, d_roll, d_yaw}); end
      n_tests++; if (thrst !== 9'h0) begin n_fail++; $display("FAIL reset_thrst got %h want 0", thrst); end
      n_tests++; if (motors_off !== 1'b1) begin n_fail++; $display("FAIL reset_motors_off got %b want 1", motors_off); end
      n_tests++; if ({inertial_cal, strt_cal, send_resp, clr_cmd_rdy} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0000", {inertial_cal, strt_cal, send_resp, clr_cmd_rdy}); end
      n_tests++; if (resp !== 8'h00) begin n_fail++; $display("FAIL reset_resp got %h want 00", resp); end
   endtask

   task automatic test_req_batt();
      batt = 8'hC0;
      do_cmd(8'h01, 16'h0000, c, s1, r, s2);
      n_tests++; if (c !== 1'b1) begin n_fail++; $display("FAIL batt_clr got %b want 1", c); end
      n_tests++; if (s1 !== 1'b1 || s2 !== 1'b0) begin n_fail++; $display("FAIL batt_send got %b%b want 10", s1, s2); end
      n_tests++; if (r !== 8'hC0) begin n_fail++; $display("FAIL batt_resp got %h want c0", r); end
      n_tests++; if ({d_ptch, d_roll, d_yaw, thrst} !== 57'h0 || motors_off !== 1'b1) begin n_fail++; $display("FAIL batt_regs got %h/%b want 0/1", {d_ptch, d_roll, d_yaw, thrst}, motors_off); end
      finish_resp();
   endtask

   task automatic test_set_regs();
      logic [7:0]  ops [4] = '{8'h02, 8'h03, 8'h04, 8'h05};
      logic [15:0] vals[4] = '{16'h00FA, 16'h00FB, 16'h00FC, 16'h00FD};
      for (int i = 0; i < 4; i++) begin
         do_cmd(ops[i], vals[i], c, s1, r, s2);
         n_tests++; if (s1 !== 1'b1 || r !== 8'hA5) begin n_fail++; $display("FAIL set_ack%0d got %b/%h want 1/a5", i, s1, r); end
         finish_resp();
      end
      n_tests++; if (d_ptch !== 16'h00FA) begin n_fail++; $display("FAIL set_ptch got %h want 00fa", d_ptch); end
      n_tests++; if (d_roll !== 16'h00FB) begin n_fail++; $display("FAIL set_roll got %h want 00fb", d_roll); end
      n_tests++; if (d_yaw !== 16'h00FC) begin n_fail++; $display("FAIL set_yaw got %h want 00fc", d_yaw); end
      n_tests++; if (thrst !== 9'h0FD) begin n_fail++; $display("FAIL set_thrst got %h want 0fd", thrst); end
   endtask

   task automatic test_mtrs_off();
      logic seen = 1'b0;
      do_cmd(8'h08, 16'h0000, c, s1, r, s2);
      n_tests++; if (r !== 8'hA5 || motors_off !== 1'b1) begin n_fail++; $display("FAIL moff_ack got %h/%b want a5/1", r, motors_off); end
      finish_resp();
      do_cmd(8'h05, 16'h0050, c, s1, r, s2);
      finish_resp();
      n_tests++; if (thrst !== 9'h050 || motors_off !== 1'b1) begin n_fail++; $display("FAIL moff_thrst got %h/%b want 050/1", thrst, motors_off); end
      cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0;
      tick();
      cmd_rdy = 1'b0;
      n_tests++; if (motors_off !== 1'b0 || thrst !== 9'h0 || inertial_cal !== 1'b1) begin n_fail++; $display("FAIL moff_cal got %b/%h/%b want 0/000/1", motors_off, thrst, inertial_cal); end
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (send_resp || strt_cal) seen = 1'b1;
         tick();
      end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_pulse got %b want 0", seen); end
      n_tests++; if (inertial_cal !== 1'b0 || motors_off !== 1'b1) begin n_fail++; $display("FAIL abort_state got %b/%b want 0/1", inertial_cal, motors_off); end
   endtask

   task automatic test_calibrate();
      int k = 0;
      do_cmd(8'h02, 16'h00FA, c, s1, r, s2);
      finish_resp();
      cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0;
      tick();
      cmd_rdy = 1'b0;
      n_tests++; if (motors_off !== 1'b0 || inertial_cal !== 1'b1 || d_ptch !== 16'h0) begin n_fail++; $display("FAIL cal_start got %b/%b/%h want 0/1/0000", motors_off, inertial_cal, d_ptch); end
      n_tests++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL cal_noresp got %b want 0", send_resp); end
      while (!strt_cal && k < 700) begin
         tick();
         k++;
      end
      n_tests++; if (k !== 512) begin n_fail++; $display("FAIL cal_spinup got %0d want 512", k); end
      tick();
      n_tests++; if (strt_cal !== 1'b0) begin n_fail++; $display("FAIL cal_strt_width got %b want 0", strt_cal); end
      repeat (99) tick();
      n_tests++; if (inertial_cal !== 1'b1 || send_resp !== 1'b0) begin n_fail++; $display("FAIL cal_wait got %b/%b want 1/0", inertial_cal, send_resp); end
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
      n_tests++; if (send_resp !== 1'b1 || resp !== 8'hA5 || inertial_cal !== 1'b0) begin n_fail++; $display("FAIL cal_done got %b/%h/%b want 1/a5/0", send_resp, resp, inertial_cal); end
      finish_resp();
   endtask

   task automatic test_emer_land();
      do_cmd(8'h02, 16'h0001, c, s1, r, s2); finish_resp();
      do_cmd(8'h03, 16'h0002, c, s1, r, s2); finish_resp();
      do_cmd(8'h04, 16'h0003, c, s1, r, s2); finish_resp();
      do_cmd(8'h05, 16'h0004, c, s1, r, s2); finish_resp();
      do_cmd(8'h07, 16'hFFFF, c, s1, r, s2);
      n_tests++; if (r !== 8'hA5 || s1 !== 1'b1) begin n_fail++; $display("FAIL emer_ack got %h/%b want a5/1", r, s1); end
      n_tests++; if ({d_ptch, d_roll, d_yaw, thrst} !== 57'h0) begin n_fail++; $display("FAIL emer_zero got %h want 0", {d_ptch, d_roll, d_yaw, thrst}); end
      finish_resp();
   endtask

   task automatic test_back_to_back();
      do_cmd(8'h04, 16'h0011, c, s1, r, s2); finish_resp();
      do_cmd(8'h3C, 16'hFFFF, c, s1, r, s2);
      n_tests++; if (r !== 8'hEE || s1 !== 1'b1) begin n_fail++; $display("FAIL nack_resp got %h/%b want ee/1", r, s1); end
      n_tests++; if (d_yaw !== 16'h0011 || d_ptch !== 16'h0) begin n_fail++; $display("FAIL nack_regs got %h/%h want 0011/0000", d_yaw, d_ptch); end
      cmd_rdy = 1'b1; cmd = 8'h04; data = 16'h0099;
      cal_done = 1'b1;
      #1;
      n_tests++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_hold got %b want 0", clr_cmd_rdy); end
      tick();
      cal_done = 1'b0;
      n_tests++; if (clr_cmd_rdy !== 1'b0 || d_yaw !== 16'h0011) begin n_fail++; $display("FAIL b2b_pending got %b/%h want 0/0011", clr_cmd_rdy, d_yaw); end
      resp_sent = 1'b1;
      tick();
      resp_sent = 1'b0;
      #1;
      n_tests++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", clr_cmd_rdy); end
      tick();
      cmd_rdy = 1'b0;
      n_tests++; if (send_resp !== 1'b1 || resp !== 8'hA5 || d_yaw !== 16'h0099) begin n_fail++; $display("FAIL b2b_load got %b/%h/%h want 1/a5/0099", send_resp, resp, d_yaw); end
      tick();
      finish_resp();
   endtask

   task automatic test_wdog();
      logic seen = 1'b0;
      do_cmd(8'h02, 16'h1234, c, s1, r, s2);
      finish_resp();
      for (int i = 0; i < 4093; i++) begin
         tick();
         if (send_resp) seen = 1'b1;
      end
      n_tests++; if (d_ptch !== 16'h1234) begin n_fail++; $display("FAIL wdog_early got %h want 1234", d_ptch); end
      tick();
      n_tests++; if (d_ptch !== 16'h0 || seen !== 1'b0 || send_resp !== 1'b0) begin n_fail++; $display("FAIL wdog_expire got %h/%b want 0000/0", d_ptch, seen); end
      n_tests++; if (motors_off !== 1'b0) begin n_fail++; $display("FAIL wdog_moff got %b want 0", motors_off); end
   endtask

   task automatic test_wdog_simul();
      do_cmd(8'h04, 16'h0055, c, s1, r, s2); finish_resp();
      do_cmd(8'h02, 16'h1234, c, s1, r, s2); finish_resp();
      repeat (4093) tick();
      n_tests++; if (d_ptch !== 16'h1234 || d_yaw !== 16'h0055) begin n_fail++; $display("FAIL simul_pre got %h/%h want 1234/0055", d_ptch, d_yaw); end
      cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h0077;
      tick();
      cmd_rdy = 1'b0;
      n_tests++; if (d_roll !== 16'h0077 || d_ptch !== 16'h0 || d_yaw !== 16'h0) begin n_fail++; $display("FAIL simul_win got %h/%h/%h want 0077/0000/0000", d_roll, d_ptch, d_yaw); end
      n_tests++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin n_fail++; $display("FAIL simul_ack got %b/%h want 1/a5", send_resp, resp); end
      tick();
      finish_resp();
      repeat (300) tick();
      n_tests++; if (d_roll !== 16'h0077) begin n_fail++; $display("FAIL simul_kick got %h want 0077", d_roll); end
   endtask

   initial begin
      test_reset();
      test_req_batt();
      test_set_regs();
      test_mtrs_off();
      test_calibrate();
      test_emer_land();
      test_back_to_back();
      test_wdog();
      test_wdog_simul();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
